ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. LED set 0xED, reset 0xFF) from the SoC to the keyboard over the same two open-collector lines the PS/2 keyboard receiver listens on. It sits beside the keyboard FIFO in the peripheral region at 0x20005000. Firmware writes a byte and polls status. The block runs the full inhibit / request-to-send / device-clocked shift / acknowledge sequence and reports success, missing ACK, or timeout.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_sync.sv | 27 ++
 rtl/ps2_host_tx.sv | 219 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmitter (and the keyboard receiver).
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    WAIT_IDLE
  } ps2_tx_state_t;

  // Device falling-edge numbers that carry parity, stop and the device ACK.
  localparam int unsigned N_PARITY = 9;
  localparam int unsigned N_STOP   = 10;
  localparam int unsigned N_ACK    = 11;

  function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                               input int unsigned us);
    return (freq_hz / 1000000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Idle bus level is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], pin};
      prev_q <= sync_q[1];
    end
  end

  assign level = sync_q[1];
  assign fall  = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, device-clocked
// shift of start/data/parity/stop, ACK sample, with start and transfer timeouts.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned FREQ_HZ          = 12000000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned XFER_TIMEOUT_US  = 2000
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       timeout_o
);

  localparam int unsigned INHIBIT_CYCLES = us_to_cycles(FREQ_HZ, INHIBIT_US);
  localparam int unsigned START_CYCLES   = us_to_cycles(FREQ_HZ, START_TIMEOUT_US);
  localparam int unsigned XFER_CYCLES    = us_to_cycles(FREQ_HZ, XFER_TIMEOUT_US);
  localparam int unsigned MAX_CYCLES_A   =
      (START_CYCLES > XFER_CYCLES) ? START_CYCLES : XFER_CYCLES;
  localparam int unsigned MAX_CYCLES     =
      (MAX_CYCLES_A > INHIBIT_CYCLES) ? MAX_CYCLES_A : INHIBIT_CYCLES;
  // +1 so the counter can hold the limit value itself.
  localparam int unsigned CNT_W          = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LIMIT  = CNT_W'(START_CYCLES);
  localparam logic [CNT_W-1:0] XFER_LIMIT   = CNT_W'(XFER_CYCLES);

  localparam logic [3:0] LAST_DATA = 4'(N_PARITY - 2);
  localparam logic [3:0] PRE_PAR   = 4'(N_PARITY - 1);
  localparam logic [3:0] PRE_STOP  = 4'(N_STOP - 1);
  localparam logic [3:0] PRE_ACK   = 4'(N_ACK - 1);

  logic clk_lvl, clk_fall;
  logic data_lvl, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n_i),
    .pin     (ps2_clk_i),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk     (clk),
    .reset_n (reset_n_i),
    .pin     (ps2_data_i),
    .level   (data_lvl),
    .fall    (data_fall_unused)
  );

  ps2_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [3:0]       n_q, n_d;
  logic [7:0]       byte_q, byte_d;
  logic             par_q, par_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             timeout_q, timeout_d;
  logic             timed_out;

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      n_q       <= '0;
      byte_q    <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      n_q       <= n_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  // Before the first device edge the start window applies, afterwards the transfer window.
  assign timed_out = (n_q == 4'd0) ? (cyc_q >= START_LIMIT) : (cyc_q >= XFER_LIMIT);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    n_d       = n_q;
    byte_d    = byte_q;
    par_d     = par_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    timeout_d = timeout_q;

    unique case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        ready_d   = 1'b1;
        if (tx_valid_i && ready_q) begin
          byte_d    = tx_data_i;
          par_d     = ~^tx_data_i;
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          clk_oe_d  = 1'b1;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
          cyc_d     = '0;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == INHIBIT_LAST) begin
          data_oe_d = 1'b1;
          state_d   = RTS;
        end
      end

      RTS: begin
        // Releasing the clock while holding data low is the request-to-send.
        clk_oe_d = 1'b0;
        cyc_d    = '0;
        n_d      = '0;
        state_d  = SHIFT;
      end

      SHIFT: begin
        cyc_d = cyc_q + 1'b1;
        if (clk_fall) begin
          n_d = n_q + 4'd1;
          if (n_q == 4'd0) begin
            cyc_d = '0;
          end
          if (n_q <= LAST_DATA) begin
            data_oe_d = ~byte_q[n_q[2:0]];
          end else if (n_q == PRE_PAR) begin
            data_oe_d = ~par_q;
          end else if (n_q == PRE_STOP) begin
            data_oe_d = 1'b0;
          end else if (n_q == PRE_ACK) begin
            ack_err_d = data_lvl;
            state_d   = WAIT_IDLE;
          end
        end else if (timed_out) begin
          timeout_d = 1'b1;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end

      WAIT_IDLE: begin
        cyc_d = cyc_q + 1'b1;
        if (clk_lvl && data_lvl) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cyc_q >= XFER_LIMIT) begin
          timeout_d = 1'b1;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign ps2_clk_oe_o  = clk_oe_q;
  assign ps2_data_oe_o = data_oe_q;
  assign tx_ready_o    = ready_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign ack_err_o     = ack_err_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a wired-AND bus and a 12.5 kHz device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned FREQ      = 12000000;
  localparam int unsigned START_US  = 1000;
  localparam int          START_CYC = (FREQ / 1000000) * START_US;
  localparam int          INH_CYC   = (FREQ / 1000000) * 100;
  localparam int          HALF      = 480;  // half period of a 12.5 kHz device clock

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       clk_oe, data_oe, tx_ready, busy, done, ack_err, timeout;
  logic       ps2_clk, ps2_data;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  logic       exp_bits[$];
  logic [1:0] exp_res[$];

  assign ps2_clk  = dev_clk & ~clk_oe;
  assign ps2_data = dev_data & ~data_oe;

  ps2_host_tx #(
    .FREQ_HZ          (FREQ),
    .INHIBIT_US       (100),
    .START_TIMEOUT_US (START_US),
    .XFER_TIMEOUT_US  (2000)
  ) dut (
    .clk           (clk),
    .reset_n_i     (reset_n),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .ps2_clk_oe_o  (clk_oe),
    .ps2_data_oe_o (data_oe),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .busy_o        (busy),
    .done_o        (done),
    .ack_err_o     (ack_err),
    .timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(~^b);
    exp_bits.push_back(1'b1);
  endtask

  task automatic sample_bit(input int k);
    logic e;
    check("bit_queue_nonempty", 32'(exp_bits.size() > 0), 1);
    if (exp_bits.size() > 0) begin
      e = exp_bits.pop_front();
      check($sformatf("line_edge%0d", k), ps2_data, e);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit keep_valid);
    int w = 0;
    while (!tx_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_send", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!keep_valid) tx_valid = 1'b0;
    check("accept_ready_busy_clkoe", {tx_ready, busy, clk_oe}, 3'b011);
  endtask

  // Starts at the first inhibit cycle; ends on the first cycle with the clock released.
  task automatic measure_inhibit();
    int n = 0;
    while (clk_oe && !data_oe && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH_CYC);
    check("rts_both_oe", {clk_oe, data_oe}, 2'b11);
    @(negedge clk);
    check("shift_entry_oe", {clk_oe, data_oe}, 2'b01);
  endtask

  // stop_edge != 0 returns shortly after that falling edge with the clock still low.
  task automatic dev_frame(input logic nack, input int stop_edge);
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 1) sample_bit(0);
      if (k == 11) begin
        dev_data = nack;
        repeat (10) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (k == stop_edge) begin
        repeat (6) @(negedge clk);
        return;
      end
      repeat (HALF / 2) @(negedge clk);
      if (k <= 10) sample_bit(k);
      repeat (HALF / 2) @(negedge clk);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      if (k < 11) repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int bound, output int cycles);
    cycles = 0;
    while (!done && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic finish_check(input int c0);
    logic [1:0] r;
    check("done_lines_released", {clk_oe, data_oe, busy}, 3'b000);
    check("res_queue_nonempty", 32'(exp_res.size() > 0), 1);
    if (exp_res.size() > 0) begin
      r = exp_res.pop_front();
      check("ackerr_timeout", {ack_err, timeout}, r);
    end
    @(negedge clk);
    check("ready_after_done", {tx_ready, done}, 2'b10);
    check("done_pulse_count", done_cnt - c0, 1);
  endtask

  task automatic run_xfer(input logic [7:0] b, input logic nack);
    int c0;
    int cyc;
    c0 = done_cnt;
    push_frame(b);
    exp_res.push_back({nack, 1'b0});
    send(b, 1'b0);
    measure_inhibit();
    dev_frame(nack, 0);
    wait_done(200, cyc);
    finish_check(c0);
  endtask

  initial begin
    int c0;
    int cyc;
    repeat (3) @(negedge clk);
    check("reset_outputs", {clk_oe, data_oe, tx_ready, busy, done, ack_err, timeout}, 7'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", tx_ready, 1);

    run_xfer(8'hED, 1'b0);
    run_xfer(8'h07, 1'b0);
    run_xfer(8'h5A, 1'b1);

    // Reset in the middle of a transfer, with tx_valid held while busy.
    c0 = done_cnt;
    push_frame(8'hFF);
    send(8'hFF, 1'b1);
    check("accept_clears_ackerr", ack_err, 0);
    measure_inhibit();
    dev_frame(1'b0, 5);
    check("held_valid_not_ready", {tx_ready, busy}, 2'b01);
    tx_valid = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    check("reset_mid_release", {clk_oe, data_oe, done, tx_ready}, 4'b0000);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_mid_reset", tx_ready, 1);
    dev_clk = 1'b1;
    exp_bits.delete();
    repeat (10) @(negedge clk);
    check("no_done_on_reset", done_cnt - c0, 0);
    check("flags_after_reset", {ack_err, timeout, busy}, 3'b000);

    // Device never clocks: start timeout.
    c0 = done_cnt;
    exp_res.push_back(2'b01);
    send(8'h12, 1'b0);
    measure_inhibit();
    wait_done(START_CYC + 100, cyc);
    check("start_timeout_cycles", cyc, START_CYC + 1);
    finish_check(c0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
